// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths, entry record and FSM state type for neuron_feeder.
package neuron_pkg;
    localparam int DATA_W = 8;
    localparam int Y_W = 18;
    typedef struct packed {
        logic signed [DATA_W-1:0] x;
        logic signed [DATA_W-1:0] w;
        logic signed [DATA_W-1:0] bias;
    } entry_t;
    typedef enum logic [1:0] {IDLE, CLEAR, HOLD, EMIT} state_t;
endpackage

// File: rtl/neuron_feeder_buf.sv
// neuron_feeder_buf: DEPTH-entry operand store, one write port, asynchronous read port.
module neuron_feeder_buf
    import neuron_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output entry_t        rdata_o
);
    entry_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem[waddr_i] <= wdata_i;
    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/neuron_feeder.sv
// neuron_feeder: buffers (x, w, bias) entries and feeds them one at a time to a neuron, streaming results.
// Define NEURON_FEEDER_CLR_EN to pulse the neuron reset (CLEAR state) before every entry.
module neuron_feeder
    import neuron_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LATENCY = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [DATA_W-1:0] in_bias,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] nrn_x,
    output logic signed [DATA_W-1:0] nrn_w,
    output logic signed [DATA_W-1:0] nrn_bias,
    output logic                     nrn_rst_n,
    input  logic signed [Y_W-1:0]    nrn_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [Y_W-1:0]    res_y
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef NEURON_FEEDER_CLR_EN
    localparam state_t FIRST = CLEAR;
    assign nrn_rst_n = rst_n && state_q != CLEAR;
`else
    localparam state_t FIRST = HOLD;
    assign nrn_rst_n = rst_n;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           rd_q, rd_d;
    logic [HW-1:0]           hold_q, hold_d;
    entry_t                  nrn_q, nrn_d, rd_entry;
    logic signed [Y_W-1:0]   res_y_q, res_y_d;
    logic                    done_q, done_d;
    logic                    we, last, load;

    neuron_feeder_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (AW'(count_q)),
        .wdata_i ('{x: in_x, w: in_w, bias: in_bias}),
        .raddr_i (rd_d),
        .rdata_o (rd_entry)
    );

    assign in_ready  = state_q == IDLE && count_q < CW'(DEPTH);
    assign we        = in_valid && in_ready;
    assign last      = CW'(rd_q) + CW'(1) == count_q;
    assign busy      = state_q != IDLE;
    assign res_valid = state_q == EMIT;
    assign done      = done_q;
    assign res_y     = res_y_q;
    assign nrn_x     = nrn_q.x;
    assign nrn_w     = nrn_q.w;
    assign nrn_bias  = nrn_q.bias;
    // Operands latch only when a new entry starts, so EMIT stalls leave the neuron untouched.
    assign load  = (state_d == CLEAR || state_d == HOLD) && (state_q == IDLE || state_q == EMIT);
    assign nrn_d = load ? rd_entry : nrn_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        hold_d  = hold_q;
        res_y_d = res_y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = we ? count_q + CW'(1) : count_q;
                if (start && count_q != '0) begin
                    rd_d    = '0;
                    state_d = FIRST;
                end
            end
            CLEAR: state_d = HOLD;
            HOLD: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HW'(LATENCY - 1)) begin
                    hold_d  = '0;
                    res_y_d = nrn_y;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    state_d = last ? IDLE : FIRST;
                    rd_d    = last ? '0 : rd_q + AW'(1);
                    count_d = last ? '0 : count_q;
                    done_d  = last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            rd_q    <= '0;
            hold_q  <= '0;
            nrn_q   <= '0;
            res_y_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            hold_q  <= hold_d;
            nrn_q   <= nrn_d;
            res_y_q <= res_y_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_neuron_feeder.sv
// tb_neuron_feeder: random batches through neuron_feeder with a ReLU neuron, checked against a queue model.
module tb_neuron_feeder;
    import neuron_pkg::*;
    localparam int DEPTH = 8;
    localparam int LATENCY = 7;
`ifdef NEURON_FEEDER_CLR_EN
    localparam int PERIOD = LATENCY + 2;
    localparam bit CLR = 1'b1;
`else
    localparam int PERIOD = LATENCY + 1;
    localparam bit CLR = 1'b0;
`endif

    logic clk, rst_n, in_valid, in_ready, start, busy, done, nrn_rst_n, res_valid, res_ready;
    logic signed [DATA_W-1:0] in_x, in_w, in_bias, nrn_x, nrn_w, nrn_bias;
    logic signed [Y_W-1:0] nrn_y, res_y;

    int n_tests, n_fail, model_cnt;
    int exp_y[$];
    int exp_x[$];

    neuron_feeder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .start(start), .busy(busy), .done(done),
        .nrn_x(nrn_x), .nrn_w(nrn_w), .nrn_bias(nrn_bias), .nrn_rst_n(nrn_rst_n), .nrn_y(nrn_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nrn_ref(int x, int w, int b);
        int s = x * w + b;
        return s < 0 ? 0 : s;
    endfunction

    // Neuron: registered ReLU(x*w+bias), cleared by its own reset.
    always_ff @(posedge clk or negedge nrn_rst_n)
        if (!nrn_rst_n) nrn_y <= '0;
        else nrn_y <= Y_W'(nrn_ref(int'(nrn_x), int'(nrn_w), int'(nrn_bias)));

    task automatic chk(string tag, longint got, longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_nrn_x", nrn_x, 0);
        chk("rst_nrn_w", nrn_w, 0);
        chk("rst_nrn_bias", nrn_bias, 0);
        chk("rst_nrn_rst_n", nrn_rst_n, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    task automatic load(int x, int w, int b);
        in_valid = 1'b1;
        in_x = DATA_W'(x);
        in_w = DATA_W'(w);
        in_bias = DATA_W'(b);
        chk("in_ready", in_ready, model_cnt < DEPTH);
        if (model_cnt < DEPTH) begin
            exp_x.push_back(x);
            exp_y.push_back(nrn_ref(x, w, b));
            model_cnt++;
        end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic load_rand(int n);
        for (int i = 0; i < n; i++)
            load($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 5 EMIT cycles per result
    task automatic run_batch(int mode);
        int nexp, got, dones, clr_cnt, cyc, last_hs, stall;
        logic prev_wait;
        logic signed [Y_W-1:0] prev_y;
        logic signed [DATA_W-1:0] prev_x;
        nexp = exp_y.size();
        got = 0; dones = 0; clr_cnt = 0; cyc = 0; last_hs = -1; stall = 0;
        prev_wait = 1'b0; prev_y = '0; prev_x = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while ((got < nexp || dones == 0) && cyc < 4000) begin
            start = cyc == 3;
            in_valid = cyc == 3;
            if (cyc == 3) chk("in_ready_busy", in_ready, 0);
            res_ready = mode == 0 ? 1'b1 : mode == 1 ? $urandom_range(0, 2) != 0 : stall >= 5;
            if (res_valid) begin
                if (prev_wait) begin
                    chk("res_y_stable", res_y, prev_y);
                    chk("nrn_x_stable", nrn_x, prev_x);
                end
                if (res_ready) begin
                    if (got < nexp) begin
                        chk("res_y", res_y, exp_y.pop_front());
                        chk("nrn_x", nrn_x, exp_x.pop_front());
                    end else chk("extra_result", got + 1, nexp);
                    if (mode == 0 && last_hs >= 0) chk("period", cyc - last_hs, PERIOD);
                    last_hs = cyc;
                    got++;
                    stall = 0;
                end else stall++;
                prev_wait = !res_ready;
                prev_y = res_y;
                prev_x = nrn_x;
            end else prev_wait = 1'b0;
            if (busy && !nrn_rst_n) clr_cnt++;
            if (done) begin
                dones++;
                chk("done_after_last", got, nexp);
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b0;
        chk("results", got, nexp);
        chk("done_count", dones, 1);
        chk("busy_after", busy, 0);
        chk("clear_cycles", clr_cnt, CLR ? nexp : 0);
        tick;
        chk("done_pulse", done, 0);
        model_cnt = 0;
    endtask

    initial begin
        int cyc;
        n_tests = 0; n_fail = 0; model_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
        in_x = '0; in_w = '0; in_bias = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset;
        rst_n = 1'b1;
        tick;
        chk("nrn_rst_n_idle", nrn_rst_n, 1);

        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("empty_busy", busy, 0);
            chk("empty_res_valid", res_valid, 0);
            tick;
        end

        load(3, 2, 1);
        load(10, 10, -5);
        load(-5, 5, 4);
        load(100, 1, -128);
        load(4, 4, 4);
        run_batch(0);

        load_rand(DEPTH + 1);
        run_batch(1);

        load_rand(3);
        run_batch(2);

        for (int b = 0; b < 4; b++) begin
            load_rand($urandom_range(1, DEPTH));
            run_batch($urandom_range(0, 2));
        end

        load_rand(4);
        res_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 100) begin
            tick;
            cyc++;
        end
        chk("pre_reset_valid", res_valid, 1);
        chk("pre_reset_y", res_y, exp_y[0]);
        repeat (3) tick;
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset;
        tick;
        rst_n = 1'b1;
        res_ready = 1'b0;
        exp_x.delete();
        exp_y.delete();
        model_cnt = 0;
        tick;
        load_rand(3);
        run_batch(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
